mem_block: RTL and testbench

//  Single-port synchronous RAM, one write/read port, registered read data (1-cycle latency).

---
 rtl/mb_pkg.sv | 14 +
 rtl/mb_scrub_seq.sv | 56 +++++
 rtl/mem_block.sv | 76 +++++++
 tb/tb_mem_block.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared types and helpers for the k-means point-set RAM (mem_block).
// Optional build macro: MB_SCRUB_EN (zero-fill on reset release).
package mb_pkg;

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_RUN   = 1'b1
  } scrub_st_e;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mb_scrub_seq.sv
// Zero-fill sequencer: walks addresses 0..size-1 once after reset release.
// Only compiled when MB_SCRUB_EN is defined.
`ifdef MB_SCRUB_EN
module mb_scrub_seq
  import mb_pkg::*;
#(
  parameter int size = 100,
  parameter int AW   = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          scrub_we,
  output logic [AW-1:0] scrub_addr,
  output logic          ready
);

  scrub_st_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done;

  assign done = (cnt_q == AW'(size - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCRUB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_SCRUB: begin
        cnt_d = cnt_q + AW'(1);
        if (done) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: state_d = S_RUN;
      default: state_d = S_SCRUB;
    endcase
  end

  always_comb begin
    scrub_we   = (state_q == S_SCRUB);
    scrub_addr = cnt_q;
    ready      = (state_q == S_RUN);
  end

endmodule
`endif

// File: rtl/mem_block.sv
// Single-port RAM with registered read (read-first) for k-means points.
// Define MB_SCRUB_EN to zero the array after every reset release.
module mem_block
  import mb_pkg::*;
#(
  parameter int wel  = 24,
  parameter int size = 100,
  localparam int AW  = addr_w(size)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [wel-1:0] din,
  input  logic [AW-1:0]  addr,
  output logic [wel-1:0] dout,
  output logic           ready
);

  logic [wel-1:0] mem [size];
  logic [wel-1:0] dout_d, dout_q;
  logic           in_rng;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [wel-1:0] wr_data;

  assign in_rng = ({1'b0, addr} < (AW+1)'(size));

`ifdef MB_SCRUB_EN
  logic          sc_we;
  logic [AW-1:0] sc_addr;

  mb_scrub_seq #(
    .size(size),
    .AW  (AW)
  ) u_scrub (
    .clk       (clk),
    .rst_n     (reset),
    .scrub_we  (sc_we),
    .scrub_addr(sc_addr),
    .ready     (ready)
  );
`else
  assign ready = 1'b1;
`endif

  // reset level gates the array write so an edge inside reset is dropped
  always_comb begin
    wr_en   = reset & ready & we & in_rng;
    wr_addr = addr;
    wr_data = din;
`ifdef MB_SCRUB_EN
    if (sc_we) begin
      wr_en   = reset;
      wr_addr = sc_addr;
      wr_data = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    dout_d = '0;
    if (ready && in_rng) dout_d = mem[addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_mem_block.sv
// Directed self-checking bench for mem_block (wel=24, size=100).
// Covers both default and MB_SCRUB_EN builds.
module tb_mem_block;

  localparam int WEL  = 24;
  localparam int SIZE = 100;
  localparam int AW   = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           we = 1'b0;
  logic [WEL-1:0] din = '0;
  logic [AW-1:0]  addr = '0;
  logic [WEL-1:0] dout;
  logic           ready;

  logic [WEL-1:0] exp_mem [SIZE];
  int checks = 0;
  int fails  = 0;
  int n;

  always #5 clk = ~clk;

  mem_block #(
    .wel (WEL),
    .size(SIZE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .din  (din),
    .addr (addr),
    .dout (dout),
    .ready(ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [WEL-1:0] obs,
                     input logic [WEL-1:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    // 1. reset state
    reset = 1'b0;
    addr  = 7'd5;
    #3;
    chk("rst_dout", dout, 24'h0);
`ifdef MB_SCRUB_EN
    chk("rst_ready", {23'b0, ready}, 24'h0);
`else
    chk("rst_ready", {23'b0, ready}, 24'h1);
`endif
    step();
    step();
    chk("rst_dout_hold", dout, 24'h0);
    reset = 1'b1;

`ifdef MB_SCRUB_EN
    // 6. scrub length, we ignored, dout held 0
    we   = 1'b1;
    addr = 7'd10;
    din  = 24'hABCDEF;
    step();
    chk("scrub_ready0", {23'b0, ready}, 24'h0);
    chk("scrub_dout0", dout, 24'h0);
    wait_ready(n);
    we = 1'b0;
    chk("scrub_len", WEL'(n + 1), 24'd100);
    step();
    chk("scrub_rd10", dout, 24'h0);
`endif

    // 2. load 0..99, read back
    for (int i = 0; i < SIZE; i++) begin
      we   = 1'b1;
      addr = AW'(i);
      din  = 24'h010203 + WEL'(i);
      exp_mem[i] = din;
      step();
    end
    we   = 1'b0;
    addr = 7'd0;
    step();
    chk("rd0", dout, 24'h010203);
    addr = 7'd1;
    step();
    chk("rd1", dout, 24'h010204);
    addr = 7'd99;
    step();
    chk("rd99", dout, 24'h010266);

    // 3. read-during-write
    we   = 1'b1;
    addr = 7'd7;
    din  = 24'hAAAAAA;
    step();
    din = 24'h555555;
    step();
    chk("rdw_old", dout, 24'hAAAAAA);
    we = 1'b0;
    exp_mem[7] = 24'h555555;
    step();
    chk("rdw_new", dout, 24'h555555);

    // 4. out of range
    we   = 1'b1;
    addr = 7'd120;
    din  = 24'hFFFFFF;
    step();
    chk("oor_dout", dout, 24'h0);
    we   = 1'b0;
    addr = 7'd127;
    step();
    chk("oor_rd127", dout, 24'h0);
    for (int i = 0; i < SIZE; i++) begin
      addr = AW'(i);
      step();
      chk($sformatf("intact%0d", i), dout, exp_mem[i]);
    end

    // 5. reset mid-run
    we   = 1'b1;
    addr = 7'd3;
    din  = 24'h123456;
    step();
    we = 1'b0;
    step();
    chk("pre_rst_rd3", dout, 24'h123456);
    we    = 1'b1;
    din   = 24'h777777;
    reset = 1'b0;
    #1;
    chk("midrst_dout", dout, 24'h0);
    step();
    step();
    chk("midrst_hold", dout, 24'h0);
    reset = 1'b1;
    we    = 1'b0;
`ifdef MB_SCRUB_EN
    wait_ready(n);
    chk("rescrub_len", WEL'(n), 24'd100);
    step();
    chk("post_rst_rd3", dout, 24'h0);
    // restart at scrub cycle 50
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (50) step();
    chk("restart_mid", {23'b0, ready}, 24'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    wait_ready(n);
    chk("restart_len", WEL'(n), 24'd100);
`else
    step();
    chk("post_rst_rd3", dout, 24'h123456);
    chk("post_rst_ready", {23'b0, ready}, 24'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
